// File: rtl/cache_coh_pkg.sv
// ============================================================================
// Module : cache_coh_pkg
// Brief  : Types and widths shared by the coherenter and invalidate queue.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cache_coh_pkg;

    localparam int ADDR_W   = 16;
    // change word: {valid, 8-bit data, 16-bit addr}
    localparam int CHANGE_W = 25;

    typedef enum logic [0:0] {
        INVQ_NORMAL = 1'b0,
        INVQ_FLUSH  = 1'b1
    } invq_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/inv_fifo.sv
// ============================================================================
// Module : inv_fifo
// Brief  : Synchronous FIFO with wrap pointers, occupancy and a clear input.
//          With INV_QUEUE_DEDUP_EN defined it also exposes its storage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module inv_fifo #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_data,
    input  logic                       rd_en,
    output logic [ADDR_W-1:0]          head,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty,
`ifdef INV_QUEUE_DEDUP_EN
    output logic [DEPTH-1:0][ADDR_W-1:0] entries,
    output logic [DEPTH-1:0]           occupied,
`endif
    output logic [$clog2(DEPTH)-1:0]   rd_ptr
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    count;

    // Clear takes priority; a write in the clear cycle becomes the sole entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            if (wr_en) begin
                mem[0] <= wr_data;
                wr_ptr <= PTR_W'(1);
                count  <= (PTR_W+1)'(1);
            end else begin
                wr_ptr <= '0;
                count  <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign level = count;
    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);

`ifdef INV_QUEUE_DEDUP_EN
    // Slot i is live when its distance from the read pointer is below the count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries[i]  = mem[i];
            occupied[i] = ({1'b0, PTR_W'(i) - rd_ptr} < count);
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/cache_invalidate_queue.sv
// ============================================================================
// Module : cache_invalidate_queue
// Brief  : Per-core invalidate buffer with overflow-to-flush escalation.
//          Optional macro INV_QUEUE_DEDUP_EN drops arrivals matching a live entry.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cache_invalidate_queue
    import cache_coh_pkg::*;
#(
    parameter int ADDR_W = cache_coh_pkg::ADDR_W,
    parameter int DEPTH  = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        inv_in,
    output logic                     inv_valid,
    output logic [ADDR_W-1:0]        inv_addr,
    input  logic                     inv_ready,
    output logic                     flush_req,
    input  logic                     flush_ack,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               drop_count
);

    localparam int PTR_W = $clog2(DEPTH);

    invq_state_t      state;
    invq_state_t      state_next;
    logic             arrival;
    logic             deq;
    logic             dup;
    logic             wr_en;
    logic             clear;
    logic             drop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [ADDR_W-1:0] fifo_head;
    logic [PTR_W-1:0] fifo_rd_ptr;

`ifdef INV_QUEUE_DEDUP_EN
    logic [DEPTH-1:0][ADDR_W-1:0] fifo_entries;
    logic [DEPTH-1:0]             fifo_occupied;
`endif

    inv_fifo #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .clear    (clear),
        .wr_en    (wr_en),
        .wr_data  (inv_in),
        .rd_en    (deq),
        .head     (fifo_head),
        .level    (level),
        .full     (fifo_full),
        .empty    (fifo_empty),
`ifdef INV_QUEUE_DEDUP_EN
        .entries  (fifo_entries),
        .occupied (fifo_occupied),
`endif
        .rd_ptr   (fifo_rd_ptr)
    );

    assign arrival   = (inv_in != '0);
    assign inv_valid = (state == INVQ_NORMAL) && !fifo_empty;
    assign inv_addr  = fifo_head;
    assign flush_req = (state == INVQ_FLUSH);
    assign deq       = inv_valid && inv_ready;

`ifdef INV_QUEUE_DEDUP_EN
    // The head counts as live even when it leaves this same cycle.
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_occupied[i] && (fifo_entries[i] == inv_in)) dup = 1'b1;
        end
    end
`else
    assign dup = 1'b0;
`endif

    always_comb begin
        wr_en      = 1'b0;
        clear      = 1'b0;
        drop       = 1'b0;
        state_next = state;
        case (state)
            INVQ_NORMAL: begin
                if (arrival) begin
                    if (dup) begin
                        drop = 1'b1;
                    end else if (fifo_full && !deq) begin
                        drop       = 1'b1;
                        state_next = INVQ_FLUSH;
                    end else begin
                        wr_en = 1'b1;
                    end
                end
            end
            INVQ_FLUSH: begin
                // The flush covers anything that arrives before the ack.
                if (flush_ack) begin
                    clear      = 1'b1;
                    wr_en      = arrival;
                    state_next = INVQ_NORMAL;
                end else if (arrival) begin
                    drop = 1'b1;
                end
            end
            default: state_next = INVQ_NORMAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= INVQ_NORMAL;
            drop_count <= '0;
        end else begin
            state <= state_next;
            if (drop) drop_count <= sat_inc8(drop_count);
        end
    end

    // Read pointer is only needed by the dedup window inside the FIFO.
    logic unused_rd_ptr;
    assign unused_rd_ptr = ^fifo_rd_ptr;

endmodule

`default_nettype wire

// File: tb/tb_cache_invalidate_queue.sv
// ============================================================================
// Module : tb_cache_invalidate_queue
// Brief  : Directed, table-driven bench for cache_invalidate_queue.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cache_invalidate_queue;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] inv_in;
    logic        inv_valid;
    logic [15:0] inv_addr;
    logic        inv_ready;
    logic        flush_req;
    logic        flush_ack;
    logic [3:0]  level;
    logic [7:0]  drop_count;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [15:0] in;
        logic        rdy;
        logic        ack;
        logic        v;
        logic [15:0] a;
        logic        f;
        logic [3:0]  l;
        logic [7:0]  d;
    } vec_t;

    vec_t vecs[$];

    cache_invalidate_queue #(.ADDR_W(16), .DEPTH(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .inv_in     (inv_in),
        .inv_valid  (inv_valid),
        .inv_addr   (inv_addr),
        .inv_ready  (inv_ready),
        .flush_req  (flush_req),
        .flush_ack  (flush_ack),
        .level      (level),
        .drop_count (drop_count)
    );

    always #5 clock = ~clock;

    function automatic void add(input int in, input bit rdy, input bit ack,
                                input bit v, input int a, input bit f,
                                input int l, input int d);
        vec_t t;
        t.in = 16'(in); t.rdy = rdy; t.ack = ack;
        t.v = v; t.a = 16'(a); t.f = f; t.l = 4'(l); t.d = 8'(d);
        vecs.push_back(t);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_eq(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic check_vec(input int idx, input vec_t t);
        bit ok;
        ok = (inv_valid === t.v) && (flush_req === t.f) && (level === t.l) &&
             (drop_count === t.d) && (!t.v || (inv_addr === t.a));
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL vec%0d: got valid=%0d addr=%0d flush=%0d level=%0d drop=%0d, expected valid=%0d addr=%0d flush=%0d level=%0d drop=%0d",
                     idx, inv_valid, inv_addr, flush_req, level, drop_count,
                     t.v, t.a, t.f, t.l, t.d);
        end
    endtask

    initial begin
        // Single transfer, then a flush_ack while NORMAL must be ignored.
        add(100, 1, 0, 1, 100, 0, 1, 0);
        add(0,   1, 0, 0, 0,   0, 0, 0);
        add(0,   0, 1, 0, 0,   0, 0, 0);
        // Backpressure: fill 1..8, head held at 1, then drain in order.
        for (int k = 1; k <= 8; k++) add(k, 0, 0, 1, 1, 0, k, 0);
        for (int j = 1; j <= 8; j++) add(0, 1, 0, j < 8, j + 1, 0, 8 - j, 0);
        // Overflow into FLUSH, a counted arrival, then ack with a new arrival.
        for (int k = 1; k <= 8; k++) add(k, 0, 0, 1, 1, 0, k, 0);
        add(9,  0, 0, 0, 0,  1, 8, 1);
        add(10, 0, 0, 0, 0,  1, 8, 2);
        add(11, 0, 1, 1, 11, 0, 1, 2);
        // Full with simultaneous enqueue and dequeue: 50 becomes the tail.
        for (int k = 2; k <= 8; k++) add(10 + k, 0, 0, 1, 11, 0, k, 2);
        add(50, 1, 0, 1, 12, 0, 8, 2);
        for (int j = 1; j <= 8; j++) add(0, 1, 0, j < 8, (j <= 6) ? 12 + j : 50, 0, 8 - j, 2);

        // Reset held with a pending arrival: nothing is accepted.
        reset = 1'b0; inv_in = 16'h0064; inv_ready = 1'b0; flush_ack = 1'b0;
        repeat (3) step();
        expect_eq("rst_valid", inv_valid, 0);
        expect_eq("rst_addr",  inv_addr,  0);
        expect_eq("rst_flush", flush_req, 0);
        expect_eq("rst_level", level,     0);
        expect_eq("rst_drop",  drop_count, 0);
        reset = 1'b1;
        step();
        expect_eq("first_level", level, 1);
        expect_eq("first_addr",  inv_valid ? int'(inv_addr) : -1, 100);
        inv_in = 16'h0; inv_ready = 1'b1;
        step();
        expect_eq("first_drain", level, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            inv_in = vecs[i].in; inv_ready = vecs[i].rdy; flush_ack = vecs[i].ack;
            step();
            check_vec(i, vecs[i]);
        end
        inv_in = 16'h0; inv_ready = 1'b0; flush_ack = 1'b0;

        // Duplicate address arrival.
        inv_in = 16'd5;
        step();
        expect_eq("dup_first_level", level, 1);
        step();
`ifdef INV_QUEUE_DEDUP_EN
        expect_eq("dup_level", level, 1);
        expect_eq("dup_drop",  drop_count, 3);
`else
        expect_eq("dup_level", level, 2);
        expect_eq("dup_drop",  drop_count, 2);
`endif
        inv_in = 16'h0; inv_ready = 1'b1;
        expect_eq("dup_head0", inv_valid ? int'(inv_addr) : -1, 5);
        step();
`ifdef INV_QUEUE_DEDUP_EN
        expect_eq("dup_empty", inv_valid, 0);
`else
        expect_eq("dup_head1", inv_valid ? int'(inv_addr) : -1, 5);
        step();
        expect_eq("dup_empty", inv_valid, 0);
`endif

        // Drop counter saturation while stuck in FLUSH.
        inv_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin inv_in = 16'(k); step(); end
        expect_eq("sat_full", level, 8);
        inv_in = 16'h0100;
        repeat (300) step();
        expect_eq("sat_drop",  drop_count, 255);
        expect_eq("sat_flush", flush_req, 1);
        inv_in = 16'h0; flush_ack = 1'b1;
        step();
        flush_ack = 1'b0;
        expect_eq("sat_ack_flush", flush_req, 0);
        expect_eq("sat_ack_level", level, 0);
        expect_eq("sat_ack_drop",  drop_count, 255);

        // Asynchronous reset mid-operation.
        inv_in = 16'd1; step();
        inv_in = 16'd2; step();
        expect_eq("mid_level", level, 2);
        inv_in = 16'h0;
        #2 reset = 1'b0;
        #1;
        expect_eq("mid_rst_level", level, 0);
        expect_eq("mid_rst_valid", inv_valid, 0);
        expect_eq("mid_rst_drop",  drop_count, 0);
        expect_eq("mid_rst_flush", flush_req, 0);
        expect_eq("mid_rst_addr",  inv_addr, 0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
